seg7_result_decoder: RTL and testbench

//  Receive-side counterpart of the 7-segment encoders on the slot display bus.

---
 rtl/seg7_result_decoder_if.sv | 26 ++
 rtl/seg7_result_decoder.sv | 160 ++++++++++++++++
 tb/tb_seg7_result_decoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_result_decoder_if.sv
// Slot display bus: three active-low segment buses in, decoded digits/flags out.
interface seg7_result_decoder_if #(
  parameter int WIN_CNT_W = 8
);
  logic [6:0]           iSEG0;
  logic [6:0]           iSEG1;
  logic [6:0]           iSEG2;
  logic [3:0]           oDIG0;
  logic [3:0]           oDIG1;
  logic [3:0]           oDIG2;
  logic                 o_valid;
  logic                 o_invalid;
  logic                 o_jackpot;
  logic                 o_pair;
  logic [WIN_CNT_W-1:0] win_count;

  modport master (
    output iSEG0, iSEG1, iSEG2,
    input  oDIG0, oDIG1, oDIG2, o_valid, o_invalid, o_jackpot, o_pair, win_count
  );

  modport slave (
    input  iSEG0, iSEG1, iSEG2,
    output oDIG0, oDIG1, oDIG2, o_valid, o_invalid, o_jackpot, o_pair, win_count
  );
endinterface

// File: rtl/seg7_result_decoder.sv
// Samples three 7-segment buses, waits for a stable pattern, decodes the digits
// and classifies the result (jackpot / pair / invalid) with a saturating win count.
module seg7_digit_decode (
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       ok
);
  always_comb begin
    digit = 4'h0;
    ok    = 1'b1;
    case (seg)
      7'b1000000: digit = 4'h0;
      7'b1111001: digit = 4'h1;
      7'b0100100: digit = 4'h2;
      7'b0110000: digit = 4'h3;
      7'b0011001: digit = 4'h4;
      7'b0010010: digit = 4'h5;
      7'b0000010: digit = 4'h6;
      7'b1111000: digit = 4'h7;
      7'b0000000: digit = 4'h8;
      7'b0010000: digit = 4'h9;
      7'b0001000: digit = 4'hA;
      7'b0000011: digit = 4'hB;
      7'b1000110: digit = 4'hC;
      7'b0100001: digit = 4'hD;
      7'b0000110: digit = 4'hE;
      7'b0001110: digit = 4'hF;
      default: begin
        digit = 4'h0;
        ok    = 1'b0;
      end
    endcase
  end
endmodule

module seg7_result_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int WIN_CNT_W     = 8
) (
  input logic                clk,
  input logic                reset,
  seg7_result_decoder_if.slave bus
);
  localparam int NUM_DIG = 3;
  localparam int CNT_W   = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      accept;

  logic [NUM_DIG-1:0][6:0]   seg_in, seg_q;
  logic [NUM_DIG-1:0][3:0]   dig;
  logic [NUM_DIG-1:0]        ok;
  logic                      match;
  logic                      eq01, eq12, eq02;
  logic                      jackpot_c, pair_c, invalid_c;

  logic [NUM_DIG-1:0][3:0]   dig_q;
  logic                      valid_q, invalid_q, jackpot_q, pair_q;
  logic [WIN_CNT_W-1:0]      win_q;

  assign seg_in = {bus.iSEG2, bus.iSEG1, bus.iSEG0};
  assign match  = (seg_in == seg_q);

  // Reset loads blank so a constant blank bus after reset settles like any pattern.
  always_ff @(posedge clk) begin
    if (reset) seg_q <= {NUM_DIG{7'h7F}};
    else       seg_q <= seg_in;
  end

  // Decoding seg_q is safe: at accept time it equals the bus being sampled.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dec
    seg7_digit_decode u_dec (
      .seg   (seg_q[g]),
      .digit (dig[g]),
      .ok    (ok[g])
    );
  end

  // An unrecognised digit never matches anything.
  assign eq01      = ok[0] & ok[1] & (dig[0] == dig[1]);
  assign eq12      = ok[1] & ok[2] & (dig[1] == dig[2]);
  assign eq02      = ok[0] & ok[2] & (dig[0] == dig[2]);
  assign jackpot_c = eq01 & eq12;
  assign pair_c    = (eq01 | eq12 | eq02) & ~jackpot_c;
  assign invalid_c = ~&ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter holds matches seen so far; the accepting match is the STABLE_CYCLES-th.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (!match) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          accept  = 1'b1;
          state_d = LOCKED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (!match) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q     <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      jackpot_q <= 1'b0;
      pair_q    <= 1'b0;
      win_q     <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        dig_q     <= dig;
        invalid_q <= invalid_c;
        jackpot_q <= jackpot_c;
        pair_q    <= pair_c;
        if (jackpot_c && win_q != {WIN_CNT_W{1'b1}})
          win_q <= win_q + 1'b1;
      end
    end
  end

  assign bus.oDIG0     = dig_q[0];
  assign bus.oDIG1     = dig_q[1];
  assign bus.oDIG2     = dig_q[2];
  assign bus.o_valid   = valid_q;
  assign bus.o_invalid = invalid_q;
  assign bus.o_jackpot = jackpot_q;
  assign bus.o_pair    = pair_q;
  assign bus.win_count = win_q;
endmodule

// File: tb/tb_seg7_result_decoder.sv
// Randomised bench for seg7_result_decoder: a run-length reference model queues
// expected results, a negedge monitor pops and compares them on o_valid.
module tb_seg7_result_decoder;
  localparam int S  = 4;
  localparam int WW = 2;
  localparam int WMAX = (1 << WW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_result_decoder_if #(.WIN_CNT_W(WW)) bus ();

  seg7_result_decoder #(.STABLE_CYCLES(S), .WIN_CNT_W(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int d0, d1, d2;
    int inv, jack, pair, win;
    int cyc;
  } res_t;

  logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  res_t q[$];
  res_t exp_cur;
  int   n_pass = 0, n_total = 0;
  int   cyc = 0;
  bit   started = 0;
  logic [20:0] last_in;
  int   run = 0;
  int   win_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lookup(input logic [6:0] p);
    int d = -1;
    for (int k = 0; k < 16; k++) if (pat[k] == p) d = k;
    return d;
  endfunction

  // Result from the spec's rules: count matching valid pairs among three digits.
  function automatic res_t classify(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    res_t r;
    int d[3];
    int np;
    d[0] = lookup(a); d[1] = lookup(b); d[2] = lookup(c);
    np = 0;
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (d[i] >= 0 && d[i] == d[j]) np++;
    r.d0   = (d[0] < 0) ? 0 : d[0];
    r.d1   = (d[1] < 0) ? 0 : d[1];
    r.d2   = (d[2] < 0) ? 0 : d[2];
    r.inv  = (d[0] < 0 || d[1] < 0 || d[2] < 0) ? 1 : 0;
    r.jack = (np == 3) ? 1 : 0;
    r.pair = (np == 1) ? 1 : 0;
    r.win  = 0;
    r.cyc  = 0;
    return r;
  endfunction

  // A result is accepted when a run of identical samples reaches S+1 long.
  task automatic model(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input bit r);
    res_t e;
    if (r) begin
      last_in = {3{7'h7F}};
      run     = 1;
      win_m   = 0;
      exp_cur = '{0, 0, 0, 0, 0, 0, 0, 0};
    end else begin
      if ({c, b, a} == last_in) run++;
      else begin
        last_in = {c, b, a};
        run     = 1;
      end
      if (run == S + 1) begin
        e = classify(a, b, c);
        if (e.jack == 1 && win_m < WMAX) win_m++;
        e.win = win_m;
        e.cyc = cyc;
        q.push_back(e);
        exp_cur = e;
      end
    end
  endtask

  task automatic step(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input bit r);
    bus.iSEG0 = a;
    bus.iSEG1 = b;
    bus.iSEG2 = c;
    reset     = r;
    @(posedge clk);
    cyc++;
    model(a, b, c, r);
    #1;
  endtask

  task automatic hold(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input int n);
    for (int i = 0; i < n; i++) step(a, b, c, 1'b0);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (started) begin
      if (bus.o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("dig0", int'(bus.oDIG0), e.d0);
          chk("dig1", int'(bus.oDIG1), e.d1);
          chk("dig2", int'(bus.oDIG2), e.d2);
          chk("invalid", int'(bus.o_invalid), e.inv);
          chk("jackpot", int'(bus.o_jackpot), e.jack);
          chk("pair", int'(bus.o_pair), e.pair);
          chk("win_count", int'(bus.win_count), e.win);
        end
      end
      chk("held_outputs",
          int'({bus.oDIG2, bus.oDIG1, bus.oDIG0, bus.o_invalid, bus.o_jackpot, bus.o_pair, bus.win_count}),
          int'({exp_cur.d2[3:0], exp_cur.d1[3:0], exp_cur.d0[3:0], exp_cur.inv[0],
                exp_cur.jack[0], exp_cur.pair[0], exp_cur.win[WW-1:0]}));
    end
  end

  function automatic logic [6:0] rand_seg();
    logic [6:0] v;
    v = 7'($urandom);
    if ($urandom_range(0, 7) != 0) v = pat[$urandom_range(0, 15)];
    return v;
  endfunction

  initial begin
    logic [6:0] a, b, c;
    int kind;
    step(7'h7F, 7'h7F, 7'h7F, 1'b1);
    started = 1;
    step(7'h7F, 7'h7F, 7'h7F, 1'b1);
    // 7,7,7 jackpot
    hold(pat[7], pat[7], pat[7], 8);
    // 3,3,5 pair
    hold(pat[3], pat[3], pat[5], 8);
    // iSEG1 toggling every 3 cycles, then settles
    for (int i = 0; i < 21; i++) step(pat[1], ((i / 3) % 2 == 0) ? pat[4] : pat[9], pat[1], 1'b0);
    hold(pat[1], pat[9], pat[1], 8);
    // invalid third digit with a valid pair
    hold(pat[2], pat[2], 7'h7F, 8);
    // repeated jackpots to saturate the counter, then a long hold
    for (int j = 0; j < 4; j++) hold(pat[j + 8], pat[j + 8], pat[j + 8], 7);
    hold(pat[11], pat[11], pat[11], 50);
    // reset lands on the accepting edge, then a full re-accept
    hold(pat[9], pat[9], pat[9], 4);
    step(pat[9], pat[9], pat[9], 1'b1);
    hold(pat[9], pat[9], pat[9], 8);
    // blank bus after reset
    hold(7'h7F, 7'h7F, 7'h7F, 8);
    // randomised patterns with random hold lengths and occasional reset
    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 3);
      a = rand_seg(); b = rand_seg(); c = rand_seg();
      if (kind == 0) begin b = a; c = a; end
      else if (kind == 1) b = a;
      if ($urandom_range(0, 29) == 0) step(a, b, c, 1'b1);
      hold(a, b, c, $urandom_range(1, 9));
    end
    hold(pat[0], pat[0], pat[0], 8);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
